// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the BCD-to-binary converter.
package bcd_pkg;
  localparam int         DIGIT_W       = 4;
  localparam int         HUND_W        = 2;
  localparam logic [3:0] BCD_CORR      = 4'd3;
  localparam logic [3:0] BCD_THRESH    = 4'd8;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_digit_corr_dn.sv
// Reverse double-dabble digit fixup: a nibble that reads 8..15 after a right
// shift had a 10 shifted into it, so pull it back by 3.
module bcd_digit_corr_dn
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  assign dout = (din >= BCD_THRESH) ? din - BCD_CORR : din;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to binary converter, one reverse double-dabble
// shift per clock, with digit-error and >255 saturation handling.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int                BIN_W   = 8,
  parameter logic [BIN_W-1:0]  SAT_VAL = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        hundred,
  input  logic [3:0]        decade,
  input  logic [3:0]        unit,
  output logic              busy,
  output logic              done,
  output logic [BIN_W-1:0]  bin_out,
  output logic              err_digit,
  output logic              err_ovf
);
  localparam int WORK_W = HUND_W + 2*DIGIT_W + BIN_W;
  localparam int NDIG   = 2;

  state_t                          state_q, state_d;
  logic [WORK_W-1:0]               work, shifted, corr;
  logic [2:0]                      cnt;
  logic                            fin;
  logic                            cap_dig, cap_ovf;
  logic                            dig_bad, ovf;
  logic [7:0]                      low_val;
  logic [NDIG-1:0][DIGIT_W-1:0]    nib_in, nib_out;

  assign shifted = work >> 1;

  // unit nibble at [BIN_W+3:BIN_W], decade nibble directly above it
  for (genvar g = 0; g < NDIG; g++) begin : g_corr
    assign nib_in[g] = shifted[BIN_W + g*DIGIT_W +: DIGIT_W];
    bcd_digit_corr_dn u_corr (.din(nib_in[g]), .dout(nib_out[g]));
  end

  always_comb begin
    corr = shifted;
    for (int g = 0; g < NDIG; g++)
      corr[BIN_W + g*DIGIT_W +: DIGIT_W] = nib_out[g];
  end

  assign dig_bad = (decade > BCD_MAX_DIGIT) || (unit > BCD_MAX_DIGIT);
  assign low_val = {4'd0, decade} * 8'd10 + {4'd0, unit};
  assign ovf     = (hundred == 2'd3) || ((hundred == 2'd2) && (low_val > 8'd55));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (fin)   state_d = DONE;
      DONE:               state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // fin marks the eighth shift done; the following edge enters DONE and
  // registers the result, giving a fixed nine-edge latency from accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work      <= '0;
      cnt       <= '0;
      fin       <= 1'b0;
      cap_dig   <= 1'b0;
      cap_ovf   <= 1'b0;
      bin_out   <= '0;
      err_digit <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          work    <= {hundred, decade, unit, {BIN_W{1'b0}}};
          cnt     <= '0;
          fin     <= 1'b0;
          cap_dig <= dig_bad;
          cap_ovf <= ovf && !dig_bad;
        end
        SHIFT: if (!fin) begin
          work <= corr;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'(BIN_W-1)) fin <= 1'b1;
        end else begin
          err_digit <= cap_dig;
          err_ovf   <= cap_ovf;
          if (cap_dig)      bin_out <= '0;
          else if (cap_ovf) bin_out <= SAT_VAL;
          else              bin_out <= work[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq against an arithmetic model.
module tb_bcd_to_bin_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] hundred;
  logic [3:0] decade, unit;
  logic       busy, done, err_digit, err_ovf;
  logic [7:0] bin_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hundred(hundred), .decade(decade),
    .unit(unit), .busy(busy), .done(done), .bin_out(bin_out),
    .err_digit(err_digit), .err_ovf(err_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int h, input int d, input int u,
                                output logic [7:0] b, output logic de, output logic oe);
    int v;
    v  = h*100 + d*10 + u;
    de = (d > 9) || (u > 9);
    oe = !de && (v > 255);
    b  = de ? 8'd0 : (oe ? 8'hFF : v[7:0]);
  endfunction

  // Called with clk just past a posedge; returns in IDLE, one cycle after done.
  task automatic convert(input logic [1:0] h, input logic [3:0] d, input logic [3:0] u,
                         input bit repulse);
    logic [7:0] eb;
    logic       ed, eo, got;
    int         n, extra;
    model(int'(h), int'(d), int'(u), eb, ed, eo);
    hundred = h; decade = d; unit = u; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      if (repulse && n == 3) begin
        start = 1'b1; hundred = 2'($urandom); decade = 4'($urandom_range(9));
        unit = 4'($urandom_range(9));
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", n, 9);
    if (got) begin
      check("bin_out", 32'(bin_out), 32'(eb));
      check("err_digit", 32'(err_digit), 32'(ed));
      check("err_ovf", 32'(err_ovf), 32'(eo));
      check("busy_done", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    if (repulse) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check("no_extra_done", extra, 0);
      check("held_bin_out", 32'(bin_out), 32'(eb));
    end
  endtask

  initial begin
    int rd;
    rst_n = 1'b0; start = 1'b0; hundred = '0; decade = '0; unit = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_errs", 32'({err_digit, err_ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert(2'd2, 4'd5, 4'd5, 1'b0);
    convert(2'd0, 4'd0, 4'd0, 1'b0);
    convert(2'd1, 4'd2, 4'd8, 1'b0);
    convert(2'd2, 4'd5, 4'd6, 1'b0);
    convert(2'd3, 4'd0, 4'd0, 1'b0);
    convert(2'd0, 4'hA, 4'd3, 1'b0);
    convert(2'd3, 4'd9, 4'hF, 1'b0);
    convert(2'd1, 4'd4, 4'd2, 1'b1);

    for (int v = 0; v < 256; v++)
      convert(2'(v / 100), 4'((v / 10) % 10), 4'(v % 10), 1'b0);

    for (int i = 0; i < 80; i++) begin
      rd = int'($urandom_range(3));
      convert(2'($urandom), (rd == 0) ? 4'($urandom) : 4'($urandom_range(9)),
              (rd == 1) ? 4'($urandom) : 4'($urandom_range(9)), 1'b0);
    end

    // Abort on the fourth shift edge: reset must clear state with no done.
    hundred = 2'd1; decade = 4'd9; unit = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bin", 32'(bin_out), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) rd++;
    end
    check("abort_no_done", rd, 0);

    convert(2'd1, 4'd9, 4'd9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
